// File: rtl/edge_frame_sequencer.sv
// Raster-scans a frame, gathers each pixel's 3x3 neighbourhood from the image RAM and hands
// the window plus destination address to the convolution datapath. Optional macro: BORDER_ZERO_EN.
module edge_frame_sequencer #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_in_base,
  input  logic [ADDR_W-1:0] addr_out_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_px,
  output logic [ADDR_W-1:0] win_dst,
  output logic              win_border,
  output logic              busy,
  output logic              done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

`ifdef BORDER_ZERO_EN
  localparam int X_FIRST = 0;
  localparam int Y_FIRST = 0;
  localparam int X_LAST  = IMG_W - 1;
  localparam int Y_LAST  = IMG_H - 1;
`else
  localparam int X_FIRST = 1;
  localparam int Y_FIRST = 1;
  localparam int X_LAST  = IMG_W - 2;
  localparam int Y_LAST  = IMG_H - 2;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ISSUE, DONE} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [3:0]        k_q, k_d;
  logic [1:0]        dx_q, dx_d, dy_q, dy_d;
  logic [ADDR_W-1:0] in_base_q, out_base_q;
  logic [ADDR_W-1:0] pix_off;
  logic              cur_border, nxt_border, last_pix;
  logic              rd_vld_p1;
  logic [3:0]        rd_slot_p1;
  logic [7:0]        slot_q [9];

  // Linear offset of pixel (x,y) inside the frame, wrapped to the address width.
  function automatic logic [ADDR_W-1:0] pix_offset(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
  endfunction

  // Signed neighbour displacement (dy-1)*IMG_W + (dx-1); two's-complement wrap gives the modulo.
  function automatic logic [ADDR_W-1:0] nbr_offset(input logic [1:0] dx, input logic [1:0] dy);
    logic signed [2:0] dx_s, dy_s;
    dx_s = $signed({1'b0, dx}) - 3'sd1;
    dy_s = $signed({1'b0, dy}) - 3'sd1;
    return ADDR_W'(dy_s) * ADDR_W'(IMG_W) + ADDR_W'(dx_s);
  endfunction

`ifdef BORDER_ZERO_EN
  function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (x == '0) || (x == XW'(IMG_W - 1)) || (y == '0) || (y == YW'(IMG_H - 1));
  endfunction

  assign cur_border = is_border(x_q, y_q);
`else
  assign cur_border = 1'b0;
`endif

  assign pix_off  = pix_offset(x_q, y_q);
  assign last_pix = (x_q == XW'(X_LAST)) && (y_q == YW'(Y_LAST));

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      k_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      k_q       <= k_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      rd_vld_p1 <= rd_en;
    end
  end

  // Read return stage: data for the read issued last cycle lands in its slot
  always_ff @(posedge clk_50M) begin
    rd_slot_p1 <= k_q;
    if (state_q == IDLE && start) begin
      in_base_q  <= addr_in_base;
      out_base_q <= addr_out_base;
    end
    if (rd_vld_p1) slot_q[rd_slot_p1] <= rd_data;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    k_d        = k_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    nxt_border = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    win_valid  = 1'b0;
    win_px     = '0;
    win_dst    = '0;
    win_border = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d  = XW'(X_FIRST);
          y_d  = YW'(Y_FIRST);
          k_d  = '0;
          dx_d = '0;
          dy_d = '0;
`ifdef BORDER_ZERO_EN
          nxt_border = is_border(x_d, y_d);
`endif
          state_d = nxt_border ? ISSUE : FETCH;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = in_base_q + pix_off + nbr_offset(dx_q, dy_q);
        if (k_q == 4'd8) begin
          k_d     = '0;
          dx_d    = '0;
          dy_d    = '0;
          state_d = CAPTURE;
        end else begin
          k_d = k_q + 4'd1;
          if (dx_q == 2'd2) begin
            dx_d = '0;
            dy_d = dy_q + 2'd1;
          end else begin
            dx_d = dx_q + 2'd1;
          end
        end
      end
      CAPTURE: begin
        busy    = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        busy       = 1'b1;
        win_valid  = 1'b1;
        win_dst    = out_base_q + pix_off;
        win_border = cur_border;
        if (!cur_border) begin
          for (int i = 0; i < 9; i++) win_px[i*8 +: 8] = slot_q[i];
        end
        if (win_ready) begin
          if (last_pix) begin
            state_d = DONE;
          end else begin
            if (x_q == XW'(X_LAST)) begin
              x_d = XW'(X_FIRST);
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
`ifdef BORDER_ZERO_EN
            nxt_border = is_border(x_d, y_d);
`endif
            state_d = nxt_border ? ISSUE : FETCH;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
